// File: rtl/ttl_key_code_debouncer.sv
// Debounces the active-low BCD code from a 74147 keypad encoder and queues each
// newly settled key press (1..9) into a small FIFO with a read handshake.
module ttl_key_code_debouncer #(
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                         Clk,
  input  logic                         Clear,
  input  logic [3:0]                   Y_bar,
  input  logic                         Read,
  output logic [3:0]                   Code,
  output logic                         Valid,
  output logic [$clog2(FIFO_DEPTH):0]  Count,
  output logic                         Overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int NW = $clog2(DEBOUNCE + 1);
  localparam logic [NW-1:0] DB_MAX   = NW'(DEBOUNCE);
  localparam logic [NW-1:0] DB_PRE   = NW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, HELD} state_t;

  logic [3:0]    samp;
  logic [3:0]    cand;
  logic [NW-1:0] cnt;
  logic          accept;

  state_t        state;
  state_t        state_next;
  logic [3:0]    held;
  logic [3:0]    held_next;
  logic          push_req;
  logic          key_ok;

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic          pop;
  logic          full;
  logic          do_push;

  // The accept pulse is raised on the edge where cnt first reaches DEBOUNCE,
  // so the FSM acts on the settled cand one edge later.
  always_ff @(posedge Clk) begin
    if (Clear) begin
      samp   <= 4'd0;
      cand   <= 4'd0;
      cnt    <= '0;
      accept <= 1'b0;
    end else begin
      samp <= ~Y_bar;
      if (samp != cand) begin
        cand   <= samp;
        cnt    <= NW'(1);
        accept <= (DEBOUNCE == 1);
      end else begin
        if (cnt != DB_MAX) cnt <= cnt + 1'b1;
        accept <= (cnt == DB_PRE);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Clear) begin
      state <= IDLE;
      held  <= 4'd0;
    end else begin
      state <= state_next;
      held  <= held_next;
    end
  end

  assign key_ok = (cand >= 4'd1) && (cand <= 4'd9);

  always_comb begin
    state_next = state;
    held_next  = held;
    push_req   = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (key_ok) begin
            push_req   = 1'b1;
            held_next  = cand;
            state_next = HELD;
          end
        end
        HELD: begin
          if (cand == 4'd0) begin
            state_next = IDLE;
          end else if (key_ok && (cand != held)) begin
            push_req  = 1'b1;
            held_next = cand;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign pop     = Read && (count != '0);
  assign full    = (count == CNT_FULL);
  assign do_push = push_req && (!full || pop);

  always_ff @(posedge Clk) begin
    if (Clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      count <= count + 1'b1;
      else if (!do_push && pop) count <= count - 1'b1;
      if (push_req && !do_push) ovf <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= cand;
  end

  // Propagation delays are a simulation-model notion; the clocked outputs are zero-delay.
  if (DELAY_RISE >= 0 && DELAY_FALL >= 0) begin : g_out
    assign Valid    = (count != '0);
    assign Code     = Valid ? mem[rd_ptr] : 4'd0;
    assign Count    = count;
    assign Overflow = ovf;
  end

endmodule

// File: tb/tb_ttl_key_code_debouncer.sv
// Self-checking bench for ttl_key_code_debouncer: constant vector table, directed
// corner sequences and random key activity against a run-length reference model.
module tb_ttl_key_code_debouncer;

  localparam int DEBOUNCE   = 4;
  localparam int FIFO_DEPTH = 4;

  logic       Clk = 1'b0;
  logic       Clear = 1'b1;
  logic [3:0] Y_bar = 4'b1111;
  logic       Read = 1'b0;
  logic [3:0] Code;
  logic       Valid;
  logic [2:0] Count;
  logic       Overflow;

  int checks = 0;
  int failures = 0;

  // Reference model state: FIFO contents, held key, run length of the sampled code
  // and a two-deep delay of "run just reached DEBOUNCE" flags.
  int m_q[$];
  bit m_ovf;
  int m_held;
  int run_code;
  int run_len;
  bit f1, f2;
  int c1, c2;

  typedef struct {
    logic       clr;
    logic [3:0] yb;
    logic       rd;
    int         reps;
    logic       ev;
    logic [3:0] ec;
    int         en;
    logic       eo;
  } vec_t;

  vec_t vecs[8];

  ttl_key_code_debouncer #(
    .DEBOUNCE(DEBOUNCE),
    .FIFO_DEPTH(FIFO_DEPTH),
    .DELAY_RISE(0),
    .DELAY_FALL(0)
  ) dut (
    .Clk(Clk),
    .Clear(Clear),
    .Y_bar(Y_bar),
    .Read(Read),
    .Code(Code),
    .Valid(Valid),
    .Count(Count),
    .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic cmp(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d time=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelStep(input bit clr, input int x, input bit rd);
    bit act;
    int acode;
    if (clr) begin
      m_q.delete();
      m_ovf    = 1'b0;
      m_held   = 0;
      run_code = 0;
      run_len  = 1;
      f1 = 1'b0; f2 = 1'b0; c1 = 0; c2 = 0;
      return;
    end
    act   = f2;
    acode = c2;
    f2 = f1;
    c2 = c1;
    if (x == run_code) begin
      if (run_len < 1000) run_len++;
    end else begin
      run_code = x;
      run_len  = 1;
    end
    f1 = (run_len == DEBOUNCE);
    c1 = run_code;
    if (rd && m_q.size() > 0) m_q.delete(0);
    if (act) begin
      if (acode == 0) begin
        m_held = 0;
      end else if (acode <= 9 && acode != m_held) begin
        m_held = acode;
        if (m_q.size() < FIFO_DEPTH) m_q.push_back(acode);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic checkModel();
    int sz;
    sz = m_q.size();
    cmp("model_valid", 8'(Valid), 8'(sz > 0));
    cmp("model_code", 8'(Code), (sz > 0) ? 8'(m_q[0]) : 8'd0);
    cmp("model_count", 8'(Count), 8'(sz));
    cmp("model_overflow", 8'(Overflow), 8'(m_ovf));
  endtask

  task automatic applyStimulus(input logic [3:0] yb, input logic rd, input logic clr);
    logic [3:0] x;
    Y_bar = yb;
    Read  = rd;
    Clear = clr;
    @(posedge Clk);
    x = ~yb;
    modelStep(clr, int'(x), rd);
    #1;
    checkModel();
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [3:0] ec,
                             input int en, input logic eo);
    cmp({name, "_valid"}, 8'(Valid), 8'(ev));
    cmp({name, "_code"}, 8'(Code), 8'(ec));
    cmp({name, "_count"}, 8'(Count), 8'(en));
    cmp({name, "_overflow"}, 8'(Overflow), 8'(eo));
  endtask

  task automatic hold(input logic [3:0] yb, input logic rd, input int n);
    repeat (n) applyStimulus(yb, rd, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 4'b1111, 1'b0, 1,  1'b0, 4'd0, 0, 1'b0};
    vecs[1] = '{1'b0, 4'b1111, 1'b0, 20, 1'b0, 4'd0, 0, 1'b0};
    vecs[2] = '{1'b0, 4'b1001, 1'b0, 5,  1'b0, 4'd0, 0, 1'b0};
    vecs[3] = '{1'b0, 4'b1001, 1'b0, 1,  1'b1, 4'd6, 1, 1'b0};
    vecs[4] = '{1'b0, 4'b1001, 1'b0, 20, 1'b1, 4'd6, 1, 1'b0};
    vecs[5] = '{1'b0, 4'b1111, 1'b0, 8,  1'b1, 4'd6, 1, 1'b0};
    vecs[6] = '{1'b0, 4'b1111, 1'b1, 1,  1'b0, 4'd0, 0, 1'b0};
    vecs[7] = '{1'b0, 4'b1111, 1'b1, 3,  1'b0, 4'd0, 0, 1'b0};

    for (int v = 0; v < 8; v++) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        applyStimulus(vecs[v].yb, vecs[v].rd, vecs[v].clr);
        checkOutput($sformatf("vec%0d", v), vecs[v].ev, vecs[v].ec, vecs[v].en, vecs[v].eo);
      end
    end

    // Bouncing key: runs of 2 never settle.
    for (int i = 0; i < 4; i++) begin
      hold(4'b1001, 1'b0, 2);
      hold(4'b1111, 1'b0, 2);
    end
    hold(4'b1111, 1'b0, 10);
    checkOutput("bounce", 1'b0, 4'd0, 0, 1'b0);

    // Roll-over 6 -> 9, then release and drain.
    hold(4'b1001, 1'b0, 8);
    hold(4'b0110, 1'b0, 8);
    hold(4'b1111, 1'b0, 8);
    checkOutput("rollover", 1'b1, 4'd6, 2, 1'b0);
    applyStimulus(4'b1111, 1'b1, 1'b0);
    checkOutput("rollover_pop1", 1'b1, 4'd9, 1, 1'b0);
    applyStimulus(4'b1111, 1'b1, 1'b0);
    checkOutput("rollover_pop2", 1'b0, 4'd0, 0, 1'b0);

    // Five presses into a four-deep FIFO, then push+pop while full.
    for (int k = 1; k <= 5; k++) begin
      logic [3:0] kc;
      kc = 4'(k);
      hold(~kc, 1'b0, 8);
      hold(4'b1111, 1'b0, 8);
    end
    checkOutput("overflow", 1'b1, 4'd1, 4, 1'b1);
    hold(4'b1000, 1'b0, 5);
    applyStimulus(4'b1000, 1'b1, 1'b0);
    checkOutput("full_push_pop", 1'b1, 4'd2, 4, 1'b1);
    hold(4'b1000, 1'b0, 2);
    hold(4'b1111, 1'b0, 8);
    hold(4'b1111, 1'b1, 3);
    checkOutput("full_tail", 1'b1, 4'd7, 1, 1'b1);

    // Invalid code 12 is ignored; Clear mid-debounce restarts the count.
    applyStimulus(4'b1111, 1'b0, 1'b1);
    checkOutput("clear", 1'b0, 4'd0, 0, 1'b0);
    hold(4'b0011, 1'b0, 20);
    checkOutput("invalid12", 1'b0, 4'd0, 0, 1'b0);
    hold(4'b1111, 1'b0, 8);
    hold(4'b1100, 1'b0, 2);
    applyStimulus(4'b1100, 1'b0, 1'b1);
    for (int i = 0; i < DEBOUNCE + 1; i++) begin
      applyStimulus(4'b1100, 1'b0, 1'b0);
      checkOutput("clear_mid_wait", 1'b0, 4'd0, 0, 1'b0);
    end
    applyStimulus(4'b1100, 1'b0, 1'b0);
    checkOutput("clear_mid_push", 1'b1, 4'd3, 1, 1'b0);

    // Random key activity against the reference model.
    for (int s = 0; s < 400; s++) begin
      logic [3:0] code;
      int len;
      code = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) code = 4'd0;
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++)
        applyStimulus(~code, ($urandom_range(0, 3) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
